// File: rtl/blink_period_meter.sv
// Measures the clk-cycle interval between toggles of an asynchronous input,
// reporting each valid interval, lock on a stable period, range errors and timeouts.
module blink_period_meter #(
    parameter int unsigned MIN_PERIOD  = 2,
    parameter int unsigned MAX_PERIOD  = 1000,
    parameter int unsigned LOCK_COUNT  = 3,
    parameter int unsigned TOLERANCE   = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        led_in,
    output logic [31:0] period_out,
    output logic        period_valid,
    output logic        locked,
    output logic        range_err,
    output logic        timeout
);

    if (MIN_PERIOD < 1) begin : g_bad_min
        $fatal(1, "blink_period_meter: MIN_PERIOD must be >= 1");
    end
    if (MAX_PERIOD < MIN_PERIOD) begin : g_bad_max
        $fatal(1, "blink_period_meter: MAX_PERIOD must be >= MIN_PERIOD");
    end
    if (LOCK_COUNT < 1) begin : g_bad_lock
        $fatal(1, "blink_period_meter: LOCK_COUNT must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "blink_period_meter: SYNC_STAGES must be >= 2");
    end

    localparam logic [31:0] MinP  = 32'(MIN_PERIOD);
    localparam logic [31:0] MaxP  = 32'(MAX_PERIOD);
    localparam logic [31:0] LockC = 32'(LOCK_COUNT);
    localparam logic [31:0] Tol   = 32'(TOLERANCE);

    typedef enum logic [1:0] {StIdle, StMeasure, StLocked} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic [31:0]            cnt_q, cnt_d;
    logic [31:0]            ref_q, ref_d;
    logic [31:0]            mc_q, mc_d;
    logic [31:0]            period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   locked_q, locked_d;
    logic                   rerr_q, rerr_d;
    logic                   to_q, to_d;
    logic                   tog;
    logic [31:0]            diff;
    logic                   is_match;
    logic [31:0]            mc_new;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            ref_q       <= '0;
            mc_q        <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            rerr_q      <= 1'b0;
            to_q        <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], led_in};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ref_q       <= ref_d;
            mc_q        <= mc_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            rerr_q      <= rerr_d;
            to_q        <= to_d;
        end
    end

    assign tog      = sync_q[SYNC_STAGES-1] ^ sync_prev_q;
    // In an edge cycle cnt_q is the measured interval.
    assign diff     = (cnt_q >= ref_q) ? (cnt_q - ref_q) : (ref_q - cnt_q);
    assign is_match = (diff <= Tol);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ref_d    = ref_q;
        mc_d     = mc_q;
        period_d = period_q;
        valid_d  = 1'b0;
        locked_d = locked_q;
        rerr_d   = 1'b0;
        to_d     = 1'b0;
        mc_new   = 32'd1;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (tog) begin
                    cnt_d   = 32'd1;
                    state_d = StMeasure;
                end
            end
            StMeasure, StLocked: begin
                if (tog) begin
                    cnt_d = 32'd1;
                    if (cnt_q < MinP) begin
                        rerr_d   = 1'b1;
                        mc_d     = '0;
                        locked_d = 1'b0;
                        state_d  = StMeasure;
                    end else begin
                        period_d = cnt_q;
                        valid_d  = 1'b1;
                        if (state_q == StLocked) begin
                            // Reference stays fixed while locked: no drift tracking.
                            if (!is_match) begin
                                locked_d = 1'b0;
                                ref_d    = cnt_q;
                                mc_d     = 32'd1;
                                state_d  = StMeasure;
                            end
                        end else begin
                            if (is_match && (mc_q != '0)) begin
                                mc_new = mc_q + 32'd1;
                            end else begin
                                ref_d = cnt_q;
                            end
                            mc_d = mc_new;
                            if (mc_new == LockC) begin
                                locked_d = 1'b1;
                                state_d  = StLocked;
                            end
                        end
                    end
                end else if (cnt_q == MaxP) begin
                    to_d     = 1'b1;
                    locked_d = 1'b0;
                    mc_d     = '0;
                    cnt_d    = '0;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign period_out   = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign range_err    = rerr_q;
    assign timeout      = to_q;

endmodule
